// File: rtl/dibu_pkg.sv
// Shared definitions for the dibu core: widths, opcodes, ALU ops, flag bits,
// FSM states and control-vector bit positions.
package dibu_pkg;

    localparam int unsigned AddrW    = 9;
    localparam int unsigned InstrW   = 16;
    localparam int unsigned DataW    = 8;
    localparam int unsigned MemDepth = 512;
    localparam int unsigned NumRegs  = 8;

    // Opcode classes: [4:3] selects ALU / CMP, full code selects MOVI, RDF, HALT
    localparam logic [1:0] ClsAlu  = 2'b00;
    localparam logic [1:0] ClsCmp  = 2'b10;
    localparam logic [4:0] OpMovi  = 5'b01000;
    localparam logic [4:0] OpRdf   = 5'b01001;
    localparam logic [4:0] OpHalt  = 5'b11111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluNot = 3'b101,
        AluShl = 3'b110,
        AluShr = 3'b111
    } alu_op_e;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagC = 2;
    localparam int unsigned FlagV = 3;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StMem    = 2'd1,
        StExec   = 2'd2,
        StHalted = 2'd3
    } state_e;

    localparam int unsigned CtlPcInc     = 0;
    localparam int unsigned CtlMarWEn    = 1;
    localparam int unsigned CtlRegRw     = 2;
    localparam int unsigned CtlRegSelIn  = 3;
    localparam int unsigned CtlFlagsWEn  = 4;
    localparam int unsigned CtlAluOutSel = 5;
    localparam int unsigned NumCtl       = 6;

    function automatic alu_op_e alu_op_of(input logic [InstrW-1:0] ir);
        return alu_op_e'(ir[13:11]);
    endfunction

endpackage

// File: rtl/dibu_if.sv
// Program-load and observation bus of the dibu core.
interface dibu_if;
    logic        run;
    logic        code_w_en;
    logic [8:0]  code_addr_in;
    logic [15:0] code_in;
    logic [7:0]  debug;

    modport master (output run, output code_w_en, output code_addr_in, output code_in,
                    input debug);
    modport slave  (input run, input code_w_en, input code_addr_in, input code_in,
                    output debug);
endinterface

// File: rtl/dibu_alu.sv
// Combinational 8-bit ALU producing a wrapped result and a Z/N/C/V flag byte.
module dibu_alu
    import dibu_pkg::*;
(
    input  alu_op_e          op,
    input  logic [DataW-1:0] a,
    input  logic [DataW-1:0] b,
    output logic [DataW-1:0] result,
    output logic [DataW-1:0] flags
);

    logic [DataW:0] sum;
    logic [DataW:0] diff;
    logic           carry;
    logic           ovf;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            AluAdd: begin
                result = sum[DataW-1:0];
                carry  = sum[DataW];
                ovf    = (a[7] == b[7]) && (result[7] != a[7]);
            end
            AluSub: begin
                result = diff[DataW-1:0];
                carry  = diff[DataW];  // borrow, set exactly when a < b
                ovf    = (a[7] != b[7]) && (result[7] != a[7]);
            end
            AluAnd: result = a & b;
            AluOr:  result = a | b;
            AluXor: result = a ^ b;
            AluNot: result = ~a;
            AluShl: begin
                result = {a[6:0], 1'b0};
                carry  = a[7];
            end
            AluShr: begin
                result = {1'b0, a[7:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
        flags        = '0;
        flags[FlagZ] = (result == '0);
        flags[FlagN] = result[7];
        flags[FlagC] = carry;
        flags[FlagV] = ovf;
    end

endmodule

// File: rtl/dibu_core.sv
// Three-phase (fetch / mem / exec) 8-bit core with 512x16 code memory,
// 8x8 register file and a flags register.
module dibu_core
    import dibu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    dibu_if.slave bus
);

    logic [InstrW-1:0] mem [MemDepth];
    logic [AddrW-1:0]  pc_q;
    logic [AddrW-1:0]  mar_q;
    logic [AddrW-1:0]  mem_addr;
    logic [InstrW-1:0] ir_q;
    logic [DataW-1:0]  flags_q;
    logic [DataW-1:0]  regs_q [NumRegs];
    state_e            state_q;
    state_e            state_d;
    logic [NumCtl-1:0] ctrl;
    logic              enable;
    logic              ir_load;

    logic [4:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [7:0]        imm8;
    logic [DataW-1:0]  alu_result;
    logic [DataW-1:0]  alu_flags;
    logic [DataW-1:0]  reg_wdata;

    assign opcode = ir_q[15:11];
    assign rd     = ir_q[10:8];
    assign imm8   = ir_q[7:0];
    assign ra     = ir_q[5:3];
    assign rb     = ir_q[2:0];

    // A code write steals the memory port, so it stalls the FSM like run=0.
    assign enable   = bus.run && !bus.code_w_en;
    assign mem_addr = bus.code_w_en ? bus.code_addr_in : mar_q;
    assign ir_load  = enable && (state_q == StMem);

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        if (enable) begin
            case (state_q)
                StFetch: begin
                    ctrl[CtlPcInc]  = 1'b1;
                    ctrl[CtlMarWEn] = 1'b1;
                    state_d         = StMem;
                end
                StMem: state_d = StExec;
                StExec: begin
                    if (opcode[4:3] == ClsAlu) begin
                        ctrl[CtlRegRw]     = 1'b1;
                        ctrl[CtlAluOutSel] = 1'b1;
                        ctrl[CtlFlagsWEn]  = 1'b1;
                    end else if (opcode[4:3] == ClsCmp) begin
                        ctrl[CtlFlagsWEn] = 1'b1;
                    end else if (opcode == OpMovi) begin
                        ctrl[CtlRegRw]    = 1'b1;
                        ctrl[CtlRegSelIn] = 1'b1;
                    end else if (opcode == OpRdf) begin
                        ctrl[CtlRegRw] = 1'b1;
                    end
                    state_d = (opcode == OpHalt) ? StHalted : StFetch;
                end
                StHalted: state_d = StHalted;
                default:  state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        if (ctrl[CtlAluOutSel]) begin
            reg_wdata = alu_result;
        end else if (ctrl[CtlRegSelIn]) begin
            reg_wdata = imm8;
        end else begin
            reg_wdata = flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (ctrl[CtlPcInc]) begin
                pc_q <= pc_q + 1'b1;
            end
            if (ctrl[CtlMarWEn]) begin
                mar_q <= pc_q;
            end
            if (ir_load) begin
                ir_q <= mem[mem_addr];
            end
            if (ctrl[CtlFlagsWEn]) begin
                flags_q <= alu_flags;
            end
            if (ctrl[CtlRegRw]) begin
                regs_q[rd] <= reg_wdata;
            end
        end
    end

    // Code memory is deliberately left out of reset so programs survive it.
    always_ff @(posedge clk) begin
        if (bus.code_w_en) begin
            mem[mem_addr] <= bus.code_in;
        end
    end

    dibu_alu u_alu (
        .op     (alu_op_of(ir_q)),
        .a      (regs_q[ra]),
        .b      (regs_q[rb]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign bus.debug = alu_result;

endmodule

// File: tb/tb_dibu_core.sv
// Self-checking bench for dibu_core: directed programs plus randomized
// program/run/write traffic against an instruction-level reference model.
module tb_dibu_core;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    dibu_if bus ();

    dibu_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_pc;
    int          m_mar;
    int          m_phase;
    bit          m_halted;
    logic [15:0] m_ir;
    logic [7:0]  m_flags;
    logic [7:0]  m_regs [8];
    logic [15:0] m_mem [512];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {flags, result} computed from integer arithmetic.
    function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
        int r;
        int c;
        int v;
        int sa;
        int sb;
        int fl;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c  = 0;
        v  = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; v = (sa + sb > 127 || sa + sb < -128); end
            1: begin r = a - b; c = (a < b) ? 1 : 0;   v = (sa - sb > 127 || sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; c = a / 128; end
            default: begin r = a / 2; c = a % 2; end
        endcase
        r  = (r + 256) % 256;
        fl = ((r == 0) ? 1 : 0) + ((r >= 128) ? 2 : 0) + c * 4 + v * 8;
        return {8'(fl), 8'(r)};
    endfunction

    task automatic model_exec();
        logic [15:0] res;
        int          opc;
        int          rd;
        opc = int'(m_ir[15:11]);
        rd  = int'(m_ir[10:8]);
        res = ref_alu(int'(m_ir[13:11]), int'(m_regs[m_ir[5:3]]), int'(m_regs[m_ir[2:0]]));
        if (opc < 8) begin
            m_regs[rd] = res[7:0];
            m_flags    = res[15:8];
        end else if (opc >= 16 && opc < 24) begin
            m_flags = res[15:8];
        end else if (opc == 8) begin
            m_regs[rd] = m_ir[7:0];
        end else if (opc == 9) begin
            m_regs[rd] = m_flags;
        end else if (opc == 31) begin
            m_halted = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_pc = 0; m_mar = 0; m_phase = 0; m_halted = 0;
            m_ir = '0; m_flags = '0;
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
        end else if (bus.code_w_en) begin
            m_mem[int'(bus.code_addr_in)] = bus.code_in;
        end else if (bus.run && !m_halted) begin
            if (m_phase == 0) begin
                m_mar   = m_pc;
                m_pc    = (m_pc + 1) % 512;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_ir    = m_mem[m_mar];
                m_phase = 2;
            end else begin
                model_exec();
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] dbg;
        dbg = ref_alu(int'(m_ir[13:11]), int'(m_regs[m_ir[5:3]]), int'(m_regs[m_ir[2:0]]));
        check("pc", 16'(dut.pc_q), 16'(m_pc));
        check("flags", 16'(dut.flags_q), 16'(m_flags));
        check("debug", 16'(bus.debug), 16'(dbg[7:0]));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("r%0d", i), 16'(dut.regs_q[i]), 16'(m_regs[i]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        bus.code_w_en    = 1'b1;
        bus.code_addr_in = 9'(addr);
        bus.code_in      = data;
        tick();
        bus.code_w_en    = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'h1F && $urandom_range(0, 15) != 0) w[15:11] = 5'h00;
        return w;
    endfunction

    initial begin
        n_vec            = 0;
        n_err            = 0;
        rst_n            = 1'b0;
        bus.run          = 1'b0;
        bus.code_w_en    = 1'b0;
        bus.code_addr_in = '0;
        bus.code_in      = '0;

        do_reset();
        check("rst_pc", 16'(dut.pc_q), 16'h0000);
        check("rst_debug", 16'(bus.debug), 16'h0000);
        check("rst_flags", 16'(dut.flags_q), 16'h0000);

        // Directed program: MOVI, MOVI, ADD, SUB, RDF, HALT
        load(0, 16'h4105);
        load(1, 16'h4203);
        load(2, 16'h030A);
        load(3, 16'h0C11);
        load(4, 16'h4D00);
        load(5, 16'hF800);
        bus.run = 1'b1;
        ticks(8);
        check("add_exec_debug", 16'(bus.debug), 16'h0008);
        tick();
        check("r1_movi", 16'(dut.regs_q[1]), 16'h0005);
        check("r2_movi", 16'(dut.regs_q[2]), 16'h0003);
        check("r3_add", 16'(dut.regs_q[3]), 16'h0008);
        ticks(3);
        check("r4_sub", 16'(dut.regs_q[4]), 16'h00FE);
        check("flags_sub", 16'(dut.flags_q), 16'h0006);
        bus.run = 1'b0;
        ticks(5);
        check("pause_pc", 16'(dut.pc_q), 16'h0004);
        bus.run = 1'b1;
        ticks(3);
        check("r5_rdf", 16'(dut.regs_q[5]), 16'h0006);
        ticks(3 + 20);
        check("halt_pc", 16'(dut.pc_q), 16'h0006);
        check("halt_r3", 16'(dut.regs_q[3]), 16'h0008);

        // Overflow and carry cases
        bus.run = 1'b0;
        do_reset();
        load(0, 16'h417F);
        load(1, 16'h4201);
        load(2, 16'h030A);
        load(3, 16'h4C00);
        load(4, 16'h41FF);
        load(5, 16'h030A);
        load(6, 16'h4C00);
        load(7, 16'hF800);
        bus.run = 1'b1;
        ticks(12);
        check("add_7f_res", 16'(dut.regs_q[3]), 16'h0080);
        check("add_7f_flags", 16'(dut.regs_q[4]), 16'h000A);
        ticks(9);
        check("add_ff_res", 16'(dut.regs_q[3]), 16'h0000);
        check("add_ff_flags", 16'(dut.regs_q[4]), 16'h0005);
        ticks(6);

        // Reset during EXEC of MOVI must suppress the write
        bus.run = 1'b0;
        do_reset();
        load(0, 16'h4155);
        bus.run = 1'b1;
        ticks(2);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.run = 1'b0;
        check("abort_r1", 16'(dut.regs_q[1]), 16'h0000);
        check("abort_pc", 16'(dut.pc_q), 16'h0000);
        bus.run = 1'b1;
        ticks(3);
        check("rerun_r1", 16'(dut.regs_q[1]), 16'h0055);

        // Randomized traffic over a fully initialised memory
        bus.run = 1'b0;
        do_reset();
        for (int a = 0; a < 512; a++) load(a, rand_instr());
        for (int c = 0; c < 2500; c++) begin
            bus.run          = ($urandom_range(0, 9) != 0);
            bus.code_w_en    = ($urandom_range(0, 19) == 0);
            bus.code_addr_in = 9'($urandom);
            bus.code_in      = rand_instr();
            rst_n            = ($urandom_range(0, 599) != 0);
            tick();
        end
        bus.code_w_en = 1'b0;
        rst_n         = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
